// File: rtl/inst_record_table.sv
// In-flight vector instruction record table: one slot per issued instruction,
// tracking retired element writes until the instruction completes.
module inst_record_table #(
   parameter int SLOTS  = 4,
   parameter int MASK_W = 128
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       alloc_valid,
   output logic                       alloc_ready,
   input  logic                       alloc_vd_valid,
   input  logic                       alloc_vs1_valid,
   input  logic                       alloc_gather,
   input  logic                       alloc_gather16,
   input  logic                       alloc_onlyRead,
   input  logic [4:0]                 alloc_vd_bits,
   input  logic [4:0]                 alloc_vs1_bits,
   input  logic [4:0]                 alloc_vs2,
   input  logic [2:0]                 alloc_instIndex,
   input  logic                       update_valid,
   input  logic [2:0]                 update_instIndex,
   input  logic [MASK_W-1:0]          update_mask,
   input  logic                       retire_valid,
   input  logic [2:0]                 retire_instIndex,
   output logic [SLOTS-1:0]           record_valid,
   output logic [SLOTS-1:0]           record_vd_valid,
   output logic [SLOTS-1:0]           record_vs1_valid,
   output logic [SLOTS-1:0]           record_gather,
   output logic [SLOTS-1:0]           record_gather16,
   output logic [SLOTS-1:0]           record_onlyRead,
   output logic [5*SLOTS-1:0]         record_vd_bits,
   output logic [5*SLOTS-1:0]         record_vs1_bits,
   output logic [5*SLOTS-1:0]         record_vs2,
   output logic [3*SLOTS-1:0]         record_instIndex,
   output logic [MASK_W*SLOTS-1:0]    record_elementMask,
   output logic [$clog2(SLOTS):0]     count,
   output logic                       update_miss
);
   localparam int IDX_W = $clog2(SLOTS);
   localparam int CNT_W = IDX_W + 1;

   logic [SLOTS-1:0]  slotValid;
   logic [SLOTS-1:0]  slotVdValid;
   logic [SLOTS-1:0]  slotVs1Valid;
   logic [SLOTS-1:0]  slotGather;
   logic [SLOTS-1:0]  slotGather16;
   logic [SLOTS-1:0]  slotOnlyRead;
   logic [4:0]        slotVd   [SLOTS];
   logic [4:0]        slotVs1  [SLOTS];
   logic [4:0]        slotVs2  [SLOTS];
   logic [2:0]        slotIdx  [SLOTS];
   logic [MASK_W-1:0] slotMask [SLOTS];
   logic [CNT_W-1:0]  countReg;
   logic              missReg;

   logic [SLOTS-1:0]  updHit;
   logic [SLOTS-1:0]  retHit;
   logic              dupHit;
   logic              anyFree;
   logic [IDX_W-1:0]  freeIdx;
   logic              allocFire;

   // Descending scan leaves freeIdx at the lowest-numbered invalid slot.
   always_comb begin
      updHit  = '0;
      retHit  = '0;
      dupHit  = 1'b0;
      anyFree = 1'b0;
      freeIdx = '0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (!slotValid[i]) begin
            anyFree = 1'b1;
            freeIdx = IDX_W'(i);
         end
      end
      for (int i = 0; i < SLOTS; i++) begin
         updHit[i] = update_valid & slotValid[i] & (slotIdx[i] == update_instIndex);
         retHit[i] = retire_valid & slotValid[i] & (slotIdx[i] == retire_instIndex);
         dupHit    = dupHit | (slotValid[i] & (slotIdx[i] == alloc_instIndex));
      end
   end

   assign alloc_ready = ~reset & anyFree & ~dupHit;
   assign allocFire   = alloc_valid & alloc_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         slotValid    <= '0;
         slotVdValid  <= '0;
         slotVs1Valid <= '0;
         slotGather   <= '0;
         slotGather16 <= '0;
         slotOnlyRead <= '0;
         for (int i = 0; i < SLOTS; i++) begin
            slotVd[i]   <= '0;
            slotVs1[i]  <= '0;
            slotVs2[i]  <= '0;
            slotIdx[i]  <= '0;
            slotMask[i] <= '0;
         end
         countReg <= '0;
         missReg  <= 1'b0;
      end else begin
         for (int i = 0; i < SLOTS; i++) begin
            // An allocating slot is invalid, so it can never also see an update or retire hit.
            if (allocFire && (freeIdx == IDX_W'(i))) begin
               slotValid[i]    <= 1'b1;
               slotVdValid[i]  <= alloc_vd_valid;
               slotVs1Valid[i] <= alloc_vs1_valid;
               slotGather[i]   <= alloc_gather;
               slotGather16[i] <= alloc_gather16;
               slotOnlyRead[i] <= alloc_onlyRead;
               slotVd[i]       <= alloc_vd_bits;
               slotVs1[i]      <= alloc_vs1_bits;
               slotVs2[i]      <= alloc_vs2;
               slotIdx[i]      <= alloc_instIndex;
               slotMask[i]     <= '0;
            end else begin
               if (updHit[i] && !retHit[i])
                  slotMask[i] <= slotMask[i] | update_mask;
               if (retHit[i])
                  slotValid[i] <= 1'b0;
            end
         end
         countReg <= countReg + CNT_W'(allocFire) - CNT_W'(|retHit);
         missReg  <= update_valid & ~(|updHit);
      end
   end

   assign record_valid     = slotValid;
   assign record_vd_valid  = slotVdValid;
   assign record_vs1_valid = slotVs1Valid;
   assign record_gather    = slotGather;
   assign record_gather16  = slotGather16;
   assign record_onlyRead  = slotOnlyRead;
   assign count            = countReg;
   assign update_miss      = missReg;

   for (genvar g = 0; g < SLOTS; g++) begin : gFlat
      assign record_vd_bits[5*g +: 5]             = slotVd[g];
      assign record_vs1_bits[5*g +: 5]            = slotVs1[g];
      assign record_vs2[5*g +: 5]                 = slotVs2[g];
      assign record_instIndex[3*g +: 3]           = slotIdx[g];
      assign record_elementMask[MASK_W*g +: MASK_W] = slotMask[g];
   end

endmodule

// File: tb/tb_inst_record_table.sv
// Scoreboard bench for inst_record_table: directed scenarios followed by random traffic,
// checked against a table-level reference model.
module tb_inst_record_table;
   localparam int SLOTS  = 4;
   localparam int MASK_W = 128;
   localparam int CW     = 3;

   typedef struct packed {
      logic       vdV;
      logic       vs1V;
      logic       g;
      logic       g16;
      logic       oR;
      logic [4:0] vd;
      logic [4:0] vs1;
      logic [4:0] vs2;
      logic [2:0] idx;
   } rec_t;
   localparam int RW = $bits(rec_t);

   typedef struct {
      logic [SLOTS-1:0]        v;
      logic [CW-1:0]           cnt;
      logic                    miss;
      logic                    rdy;
      logic [5*SLOTS-1:0]      flags;
      logic [15*SLOTS-1:0]     regs;
      logic [3*SLOTS-1:0]      idx;
      logic [MASK_W*SLOTS-1:0] mask;
   } exp_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic                    reset = 1'b1;
   logic                    alloc_valid = 1'b0, alloc_ready;
   logic                    alloc_vd_valid = 1'b0, alloc_vs1_valid = 1'b0, alloc_gather = 1'b0;
   logic                    alloc_gather16 = 1'b0, alloc_onlyRead = 1'b0;
   logic [4:0]              alloc_vd_bits = '0, alloc_vs1_bits = '0, alloc_vs2 = '0;
   logic [2:0]              alloc_instIndex = '0;
   logic                    update_valid = 1'b0;
   logic [2:0]              update_instIndex = '0;
   logic [MASK_W-1:0]       update_mask = '0;
   logic                    retire_valid = 1'b0;
   logic [2:0]              retire_instIndex = '0;
   logic [SLOTS-1:0]        record_valid, record_vd_valid, record_vs1_valid;
   logic [SLOTS-1:0]        record_gather, record_gather16, record_onlyRead;
   logic [5*SLOTS-1:0]      record_vd_bits, record_vs1_bits, record_vs2;
   logic [3*SLOTS-1:0]      record_instIndex;
   logic [MASK_W*SLOTS-1:0] record_elementMask;
   logic [CW-1:0]           count;
   logic                    update_miss;

   inst_record_table #(.SLOTS(SLOTS), .MASK_W(MASK_W)) dut (
      .clock(clock), .reset(reset),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
      .alloc_vd_valid(alloc_vd_valid), .alloc_vs1_valid(alloc_vs1_valid),
      .alloc_gather(alloc_gather), .alloc_gather16(alloc_gather16),
      .alloc_onlyRead(alloc_onlyRead),
      .alloc_vd_bits(alloc_vd_bits), .alloc_vs1_bits(alloc_vs1_bits),
      .alloc_vs2(alloc_vs2), .alloc_instIndex(alloc_instIndex),
      .update_valid(update_valid), .update_instIndex(update_instIndex),
      .update_mask(update_mask),
      .retire_valid(retire_valid), .retire_instIndex(retire_instIndex),
      .record_valid(record_valid), .record_vd_valid(record_vd_valid),
      .record_vs1_valid(record_vs1_valid), .record_gather(record_gather),
      .record_gather16(record_gather16), .record_onlyRead(record_onlyRead),
      .record_vd_bits(record_vd_bits), .record_vs1_bits(record_vs1_bits),
      .record_vs2(record_vs2), .record_instIndex(record_instIndex),
      .record_elementMask(record_elementMask),
      .count(count), .update_miss(update_miss)
   );

   int   checks = 0;
   int   errors = 0;
   exp_t q[$];

   // Reference model: the table as a set of slots, plus the stimulus for the next edge.
   logic              mV [SLOTS];
   rec_t              mR [SLOTS];
   logic [MASK_W-1:0] mM [SLOTS];
   logic              sRst = 1'b1, sAv = 1'b0, sUv = 1'b0, sRv = 1'b0;
   rec_t              sRec = '0;
   logic [2:0]        sUi = '0, sRi = '0;
   logic [MASK_W-1:0] sUm = '0;

   function automatic logic modelReady(input logic [2:0] idx);
      logic free = 1'b0;
      logic dup  = 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
         if (!mV[i]) free = 1'b1;
         else if (mR[i].idx == idx) dup = 1'b1;
      end
      return free && !dup;
   endfunction

   task automatic step();
      int   hitU, hitR, fr, pop;
      logic fire, miss;
      exp_t e;
      @(negedge clock);
      reset = sRst;           alloc_valid = sAv;
      alloc_vd_valid = sRec.vdV; alloc_vs1_valid = sRec.vs1V;
      alloc_gather = sRec.g;  alloc_gather16 = sRec.g16; alloc_onlyRead = sRec.oR;
      alloc_vd_bits = sRec.vd; alloc_vs1_bits = sRec.vs1; alloc_vs2 = sRec.vs2;
      alloc_instIndex = sRec.idx;
      update_valid = sUv; update_instIndex = sUi; update_mask = sUm;
      retire_valid = sRv; retire_instIndex = sRi;
      miss = 1'b0;
      if (sRst) begin
         for (int i = 0; i < SLOTS; i++) begin
            mV[i] = 1'b0; mR[i] = '0; mM[i] = '0;
         end
      end else begin
         fire = sAv && modelReady(sRec.idx);
         hitU = -1; hitR = -1; fr = -1;
         for (int i = 0; i < SLOTS; i++) begin
            if (!mV[i] && fr < 0) fr = i;
            if (mV[i] && sUv && mR[i].idx == sUi) hitU = i;
            if (mV[i] && sRv && mR[i].idx == sRi) hitR = i;
         end
         if (hitR >= 0) mV[hitR] = 1'b0;
         if (hitU >= 0 && hitU != hitR) mM[hitU] = mM[hitU] | sUm;
         if (fire) begin
            mV[fr] = 1'b1; mR[fr] = sRec; mM[fr] = '0;
         end
         miss = sUv && (hitU < 0);
      end
      pop = 0;
      for (int i = 0; i < SLOTS; i++) begin
         if (mV[i]) pop++;
         e.v[i] = mV[i];
         e.flags[4*SLOTS+i] = mR[i].vdV;
         e.flags[3*SLOTS+i] = mR[i].vs1V;
         e.flags[2*SLOTS+i] = mR[i].g;
         e.flags[SLOTS+i]   = mR[i].g16;
         e.flags[i]         = mR[i].oR;
         e.regs[10*SLOTS + 5*i +: 5] = mR[i].vd;
         e.regs[5*SLOTS + 5*i +: 5]  = mR[i].vs1;
         e.regs[5*i +: 5]            = mR[i].vs2;
         e.idx[3*i +: 3]             = mR[i].idx;
         e.mask[MASK_W*i +: MASK_W]  = mM[i];
      end
      e.cnt  = CW'(pop);
      e.miss = miss;
      e.rdy  = !sRst && modelReady(sRec.idx);
      q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [MASK_W*SLOTS-1:0] act,
                      input logic [MASK_W*SLOTS-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
      end
   endtask

   // Monitor: every edge the DUT presents a new table image; compare it with the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("record_valid", (MASK_W*SLOTS)'(record_valid), (MASK_W*SLOTS)'(e.v));
            chk("count", (MASK_W*SLOTS)'(count), (MASK_W*SLOTS)'(e.cnt));
            chk("update_miss", (MASK_W*SLOTS)'(update_miss), (MASK_W*SLOTS)'(e.miss));
            chk("alloc_ready", (MASK_W*SLOTS)'(alloc_ready), (MASK_W*SLOTS)'(e.rdy));
            chk("flags", (MASK_W*SLOTS)'({record_vd_valid, record_vs1_valid, record_gather,
                                          record_gather16, record_onlyRead}),
                (MASK_W*SLOTS)'(e.flags));
            chk("regspec", (MASK_W*SLOTS)'({record_vd_bits, record_vs1_bits, record_vs2}),
                (MASK_W*SLOTS)'(e.regs));
            chk("instIndex", (MASK_W*SLOTS)'(record_instIndex), (MASK_W*SLOTS)'(e.idx));
            chk("elementMask", record_elementMask, e.mask);
         end
      end
   end

   task automatic newRec(input logic [2:0] idx);
      sRec = rec_t'(RW'($urandom));
      sRec.idx = idx;
   endtask

   task automatic idle();
      sRst = 1'b0; sAv = 1'b0; sUv = 1'b0; sRv = 1'b0;
   endtask

   initial begin
      // Reset held for two cycles
      sRst = 1'b1; step(); step();
      idle();
      // Fill the table back-to-back, then offer a fifth record to a full table
      for (int k = 0; k < 4; k++) begin
         newRec(3'(k)); sAv = 1'b1; step();
      end
      newRec(3'd4); step();
      idle();
      // Accumulate two masks into instIndex 1, then miss on instIndex 5
      sUv = 1'b1; sUi = 3'd1; sUm = 128'hFF;   step();
      sUm = 128'hFF00; step();
      sUi = 3'd5; sUm = '1; step();
      idle(); step();
      // Full table: instIndex 4 pending while instIndex 2 retires
      newRec(3'd4); sAv = 1'b1; sRv = 1'b1; sRi = 3'd2; step();
      sRv = 1'b0; step(); step();
      // Duplicate index 3 offered: held off until instIndex 3 retires
      newRec(3'd3); sRv = 1'b1; sRi = 3'd0; step();
      sRv = 1'b0; step(); step();
      sRv = 1'b1; sRi = 3'd3; step();
      sRv = 1'b0; step(); step();
      idle();
      // Allocate instIndex 6 and update it in the same cycle
      newRec(3'd6); sAv = 1'b1; sUv = 1'b1; sUi = 3'd6; sUm = '1; step();
      idle(); step();
      // Update and retire of instIndex 1 together
      sUv = 1'b1; sUi = 3'd1; sUm = {4{$urandom}}; sRv = 1'b1; sRi = 3'd1; step();
      idle(); step();
      // Reset with three valid slots and an alloc offered
      newRec(3'd7); sAv = 1'b1; sRst = 1'b1; step();
      idle(); step();
      // Random traffic
      for (int n = 0; n < 400; n++) begin
         sRst = ($urandom_range(0, 99) == 0);
         sAv  = ($urandom_range(0, 9) < 6);
         newRec(3'($urandom_range(0, 7)));
         sUv  = $urandom_range(0, 1) == 1;
         sUi  = 3'($urandom_range(0, 7));
         sUm  = {$urandom, $urandom, $urandom, $urandom};
         sRv  = ($urandom_range(0, 9) < 3);
         sRi  = 3'($urandom_range(0, 7));
         step();
      end
      idle(); step();
      repeat (3) @(posedge clock);
      #3;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d want=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
